load_store_unit: RTL and testbench



---
 rtl/lsu_pkg.sv | 22 ++
 rtl/load_store_unit_if.sv | 29 ++
 rtl/load_store_unit_load_extend.sv | 16 +
 rtl/load_store_unit.sv | 129 ++++++++++++
 tb/tb_load_store_unit.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the memory-stage load/store unit: MemCtrl codes
// carried from decode and the FSM state type.
package lsu_pkg;

  localparam logic [2:0] MC_NONE = 3'b000;  // no-op, or lw when LoadM is set
  localparam logic [2:0] MC_SW   = 3'b001;
  localparam logic [2:0] MC_SB   = 3'b011;
  localparam logic [2:0] MC_LB   = 3'b010;
  localparam logic [2:0] MC_LBU  = 3'b110;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR      = 2'd2
  } lsu_state_t;

  // Word accesses must sit on a 4-byte boundary.
  function automatic logic word_misaligned(input logic [1:0] low_bits);
    return low_bits != 2'b00;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Pipeline <-> load/store unit request bundle.
//
// Handshake: the pipeline (master) raises req_m with mem_ctrl_m, load_m,
// addr_m and wdata_m and holds all of them stable until it sees done_m=1
// on a clock edge. done_m acts as ready and completion at once; rdata_m and
// err_m are only meaningful in that same cycle. A new request may be
// presented in the cycle immediately after done_m.
interface load_store_unit_if #(
  parameter int ADDR_W = 32
) ();
  logic              req_m;
  logic [2:0]        mem_ctrl_m;
  logic              load_m;
  logic [ADDR_W-1:0] addr_m;
  logic [31:0]       wdata_m;
  logic              done_m;
  logic [31:0]       rdata_m;
  logic              err_m;

  modport master (
    output req_m, mem_ctrl_m, load_m, addr_m, wdata_m,
    input  done_m, rdata_m, err_m
  );

  modport slave (
    input  req_m, mem_ctrl_m, load_m, addr_m, wdata_m,
    output done_m, rdata_m, err_m
  );
endinterface

// File: rtl/load_store_unit_load_extend.sv
// Byte select plus sign/zero extension for lb/lbu results; reusable by the
// write-back stage.
module load_extend (
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic        sign,
  output logic [31:0] ext
);
  logic [7:0] sel_byte;

  // Pick the addressed byte lane and widen it.
  always_comb begin
    sel_byte = word[8*lane +: 8];
    ext      = sign ? {{24{sel_byte[7]}}, sel_byte} : {24'b0, sel_byte};
  end
endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit driving a word-wide, one-cycle-latency SRAM
// without byte enables. sw completes with zero stall, loads take two cycles,
// sb is a read-modify-write taking three cycles.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int MEM_AW = 10
) (
  input  logic                clk,
  input  logic                rst,
  load_store_unit_if.slave    pipe,
  output logic                mem_en,
  output logic                mem_we,
  output logic [MEM_AW-1:0]   mem_addr,
  output logic [31:0]         mem_wdata,
  input  logic [31:0]         mem_rdata,
  output lsu_state_t          dbg_state
);

  lsu_state_t  state, state_d;
  logic [1:0]  lane_q;
  logic [2:0]  op_q;
  logic [31:0] merge_q;
  logic        latch;
  logic [31:0] merged;
  logic [31:0] ext_word;

  // The request is held stable by the handshake, so the word address can
  // always come straight from addr_m.
  assign mem_addr  = pipe.addr_m[MEM_AW+1:2];
  assign dbg_state = state;

  load_extend u_load_extend (
    .word (mem_rdata),
    .lane (lane_q),
    .sign (op_q == MC_LB),
    .ext  (ext_word)
  );

  // Next state and all handshake/SRAM outputs; reset forces every
  // output quiet so no write can commit on a reset edge.
  always_comb begin
    state_d               = state;
    mem_en                = 1'b0;
    mem_we                = 1'b0;
    mem_wdata             = pipe.wdata_m;
    pipe.done_m           = 1'b0;
    pipe.rdata_m          = 32'b0;
    pipe.err_m            = 1'b0;
    latch                 = 1'b0;
    merged                = mem_rdata;
    merged[8*lane_q +: 8] = pipe.wdata_m[7:0];
    if (!rst) begin
      case (state)
        IDLE: begin
          if (pipe.req_m) begin
            case (pipe.mem_ctrl_m)
              MC_NONE: begin
                if (!pipe.load_m) begin
                  pipe.done_m = 1'b1;
                end else if (word_misaligned(pipe.addr_m[1:0])) begin
                  pipe.done_m = 1'b1;
                  pipe.err_m  = 1'b1;
                end else begin
                  mem_en  = 1'b1;
                  latch   = 1'b1;
                  state_d = RD_WAIT;
                end
              end
              MC_SW: begin
                pipe.done_m = 1'b1;
                if (word_misaligned(pipe.addr_m[1:0])) begin
                  pipe.err_m = 1'b1;
                end else begin
                  mem_en = 1'b1;
                  mem_we = 1'b1;
                end
              end
              MC_SB, MC_LB, MC_LBU: begin
                mem_en  = 1'b1;
                latch   = 1'b1;
                state_d = RD_WAIT;
              end
              default: pipe.done_m = 1'b1;
            endcase
          end
        end
        RD_WAIT: begin
          if (op_q == MC_SB) begin
            state_d = WR;
          end else begin
            pipe.done_m  = 1'b1;
            pipe.rdata_m = (op_q == MC_NONE) ? mem_rdata : ext_word;
            state_d      = IDLE;
          end
        end
        WR: begin
          mem_en      = 1'b1;
          mem_we      = 1'b1;
          mem_wdata   = merge_q;
          pipe.done_m = 1'b1;
          state_d     = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State register plus the opcode/lane/merge-word latches.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      lane_q  <= 2'b0;
      op_q    <= MC_NONE;
      merge_q <= 32'b0;
    end else begin
      state <= state_d;
      if (latch) begin
        lane_q <= pipe.addr_m[1:0];
        op_q   <= pipe.mem_ctrl_m;
      end
      if (state == RD_WAIT && op_q == MC_SB) begin
        merge_q <= merged;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural SRAM and an
// expected-load-data queue.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int ADDR_W = 32;
  localparam int MEM_AW = 10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  load_store_unit_if #(.ADDR_W(ADDR_W)) pipe ();

  logic              mem_en;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  lsu_state_t        dbg_state;

  load_store_unit #(.ADDR_W(ADDR_W), .MEM_AW(MEM_AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .pipe      (pipe.slave),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .dbg_state (dbg_state)
  );

  // ---------------- SRAM model ----------------
  logic [31:0]       sram [0:(1<<MEM_AW)-1];
  logic              pre_we;
  logic [MEM_AW-1:0] pre_addr;
  logic [31:0]       pre_data;

  always @(posedge clk) begin
    if (pre_we) sram[pre_addr] <= pre_data;
    else if (mem_en) begin
      if (mem_we) sram[mem_addr] <= mem_wdata;
      else        mem_rdata <= sram[mem_addr];
    end
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int tests  = 0;
  int failed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic preload(input logic [MEM_AW-1:0] a, input logic [31:0] d);
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    @(posedge clk);
    #1 pre_we = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1 pipe.req_m = 1'b0;
    @(negedge clk);
    check("idle_done", {31'b0, pipe.done_m}, 32'd0);
    check("idle_en", {31'b0, mem_en}, 32'd0);
  endtask

  // Issue one request, follow it to done_m, check latency, SRAM traffic,
  // error flag and (for loads) the popped expected read data.
  task automatic do_op(input logic [2:0] ctrl, input logic ld, input logic [31:0] addr,
                       input logic [31:0] wdata, input int exp_cyc, input logic exp_err,
                       input int exp_rd, input int exp_wr, input logic [31:0] exp_wd,
                       input string tag);
    int cyc;
    int rd_n;
    int wr_n;
    logic seen;
    logic [31:0] exp_rdata;
    @(posedge clk);
    #1;
    pipe.req_m      = 1'b1;
    pipe.mem_ctrl_m = ctrl;
    pipe.load_m     = ld;
    pipe.addr_m     = addr;
    pipe.wdata_m    = wdata;
    cyc  = 0;
    rd_n = 0;
    wr_n = 0;
    seen = 1'b0;
    while (!seen && cyc < 8) begin
      @(negedge clk);
      cyc++;
      if (mem_en) begin
        check({tag, "_maddr"}, {22'b0, mem_addr}, {22'b0, addr[11:2]});
        if (mem_we) begin
          wr_n++;
          check({tag, "_wdata"}, mem_wdata, exp_wd);
        end else begin
          rd_n++;
        end
      end
      if (pipe.done_m) seen = 1'b1;
    end
    check({tag, "_timeout"}, {31'b0, seen}, 32'd1);
    check({tag, "_latency"}, cyc, exp_cyc);
    check({tag, "_err"}, {31'b0, pipe.err_m}, {31'b0, exp_err});
    check({tag, "_reads"}, rd_n, exp_rd);
    check({tag, "_writes"}, wr_n, exp_wr);
    if (ld) begin
      if (exp_q.size() == 0) begin
        check({tag, "_queue_empty"}, 32'd0, 32'd1);
      end else begin
        exp_rdata = exp_q.pop_front();
        check({tag, "_rdata"}, pipe.rdata_m, exp_rdata);
      end
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] data;
    logic [31:0] waddr;
    logic [1:0]  lane;

    rst             = 1'b1;
    pre_we          = 1'b0;
    pre_addr        = '0;
    pre_data        = '0;
    pipe.req_m      = 1'b0;
    pipe.mem_ctrl_m = MC_NONE;
    pipe.load_m     = 1'b0;
    pipe.addr_m     = '0;
    pipe.wdata_m    = '0;

    // Reset: outputs stay quiet even with a valid sw presented.
    repeat (2) @(posedge clk);
    #1;
    pipe.req_m      = 1'b1;
    pipe.mem_ctrl_m = MC_SW;
    pipe.addr_m     = 32'h10;
    pipe.wdata_m    = 32'h1;
    @(negedge clk);
    check("rst_en", {31'b0, mem_en}, 32'd0);
    check("rst_we", {31'b0, mem_we}, 32'd0);
    check("rst_done", {31'b0, pipe.done_m}, 32'd0);
    check("rst_err", {31'b0, pipe.err_m}, 32'd0);
    check("rst_rdata", pipe.rdata_m, 32'd0);
    check("rst_state", {30'b0, dbg_state}, {30'b0, IDLE});
    @(posedge clk);
    #1;
    rst        = 1'b0;
    pipe.req_m = 1'b0;

    // sw 0x10 <- DEADBEEF, zero stall.
    do_op(MC_SW, 1'b0, 32'h10, 32'hDEADBEEF, 1, 1'b0, 0, 1, 32'hDEADBEEF, "sw_basic");
    idle();
    check("sw_mem", sram[4], 32'hDEADBEEF);

    // lb / lbu from word 0x80FF0012 at byte 0x13 and other lanes.
    preload(10'd4, 32'h80FF0012);
    exp_q.push_back(32'hFFFFFF80);
    do_op(MC_LB, 1'b1, 32'h13, 32'h0, 2, 1'b0, 1, 0, 32'h0, "lb_lane3");
    exp_q.push_back(32'h00000080);
    do_op(MC_LBU, 1'b1, 32'h13, 32'h0, 2, 1'b0, 1, 0, 32'h0, "lbu_lane3");
    exp_q.push_back(32'hFFFFFFFF);
    do_op(MC_LB, 1'b1, 32'h12, 32'h0, 2, 1'b0, 1, 0, 32'h0, "lb_lane2");
    exp_q.push_back(32'h00000012);
    do_op(MC_LB, 1'b1, 32'h10, 32'h0, 2, 1'b0, 1, 0, 32'h0, "lb_lane0");
    idle();

    // sb read-modify-write.
    preload(10'd8, 32'h11223344);
    do_op(MC_SB, 1'b0, 32'h21, 32'h000000AB, 3, 1'b0, 1, 1, 32'h1122AB44, "sb_rmw");
    idle();
    check("sb_mem", sram[8], 32'h1122AB44);

    // Misaligned word accesses.
    exp_q.push_back(32'h0);
    do_op(MC_NONE, 1'b1, 32'h06, 32'h0, 1, 1'b1, 0, 0, 32'h0, "lw_misal");
    idle();
    preload(10'd0, 32'h00000055);
    do_op(MC_SW, 1'b0, 32'h03, 32'hCAFEF00D, 1, 1'b1, 0, 0, 32'h0, "sw_misal");
    idle();
    check("sw_misal_mem", sram[0], 32'h00000055);

    // No-op and unknown codes complete in one cycle without access.
    do_op(MC_NONE, 1'b0, 32'h40, 32'h0, 1, 1'b0, 0, 0, 32'h0, "noop");
    do_op(3'b101, 1'b0, 32'h40, 32'h0, 1, 1'b0, 0, 0, 32'h0, "unk101");
    do_op(3'b111, 1'b0, 32'h40, 32'h0, 1, 1'b0, 0, 0, 32'h0, "unk111");
    idle();

    // Reset while in WR of an sb: no write may commit.
    preload(10'd12, 32'h11223344);
    @(posedge clk);
    #1;
    pipe.req_m      = 1'b1;
    pipe.mem_ctrl_m = MC_SB;
    pipe.load_m     = 1'b0;
    pipe.addr_m     = 32'h31;
    pipe.wdata_m    = 32'h000000AB;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rstwr_state", {30'b0, dbg_state}, {30'b0, WR});
    check("rstwr_we", {31'b0, mem_we}, 32'd0);
    check("rstwr_done", {31'b0, pipe.done_m}, 32'd0);
    @(posedge clk);
    #1;
    rst        = 1'b0;
    pipe.req_m = 1'b0;
    @(negedge clk);
    check("rstwr_idle", {30'b0, dbg_state}, {30'b0, IDLE});
    check("rstwr_mem", sram[12], 32'h11223344);

    // Back-to-back lw 0x0 then sw 0x4.
    preload(10'd0, 32'h0BADF00D);
    exp_q.push_back(32'h0BADF00D);
    do_op(MC_NONE, 1'b1, 32'h0, 32'h0, 2, 1'b0, 1, 0, 32'h0, "b2b_lw");
    do_op(MC_SW, 1'b0, 32'h4, 32'h12345678, 1, 1'b0, 0, 1, 32'h12345678, "b2b_sw");
    idle();
    check("b2b_mem", sram[1], 32'h12345678);

    // Random store / load-back pairs.
    for (int i = 0; i < 6; i++) begin
      waddr = {$urandom_range(64, 127), 2'b00};
      data  = $urandom;
      lane  = 2'($urandom_range(0, 3));
      do_op(MC_SW, 1'b0, waddr, data, 1, 1'b0, 0, 1, data, "rnd_sw");
      exp_q.push_back(data);
      do_op(MC_NONE, 1'b1, waddr, 32'h0, 2, 1'b0, 1, 0, 32'h0, "rnd_lw");
      exp_q.push_back({24'b0, data[8*lane +: 8]});
      do_op(MC_LBU, 1'b1, waddr | {30'b0, lane}, 32'h0, 2, 1'b0, 1, 0, 32'h0, "rnd_lbu");
      idle();
    end

    check("queue_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
